// File: rtl/bus_data_ram.sv
// bus_data_ram -- 32-bit word-organised data RAM on a CPU-style bus.
//
// A request is read | write; the RAM holds waitrequest high for a fixed
// number of cycles before the access completes. Reads are combinational from
// the addressed word. Writes commit the enabled byte lanes at the clock edge
// that closes the completing cycle. Addresses outside the window
// [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) read as zero and ignore writes. They
// still go through the normal wait states.
//
// Build option:
//   BUS_DATA_RAM_STALL_EN -- when defined, each access is stalled for
//   WAIT_CYCLES cycles by a small IDLE/WAIT FSM with a 4-bit down-counter.
//   When undefined, the FSM is not built, waitrequest is tied low and
//   WAIT_CYCLES has no effect.

module bus_data_ram #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          DEPTH_WORDS   = 1024,
    parameter int          WAIT_CYCLES   = 2,
    parameter              RAM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata
);

    // Word-index width; a one-word RAM still needs a 1-bit index.
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // The window size in bytes. It is held in 33 bits so the compare below
    // cannot overflow.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             request;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             commit;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign request  = read | write;

    // Addresses below BASE_ADDR wrap to a large offset and fail the same
    // single compare that rejects addresses at or above the top of the window.
    assign offset   = address - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    // The byte-within-word bits are ignored. The high offset bits are already
    // covered by in_range.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[1:0], offset[31:IDX_W+2]};

    // A write lands only in its completing cycle, only inside the window, and
    // never while reset is held.
    assign commit = write & ~waitrequest & in_range & ~reset;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------

    // Power-up contents: all zeros.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] = '0;
        end
    end

    // Byte-lane write port. It commits at the edge that closes the completing cycle.
    // NOTE: the array has no reset branch. Its contents must survive reset,
    // and a reset-free array is what maps onto block RAM.
    // NOTE: registers are written with <= so that every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (byteenable[k]) begin
                    mem[word_idx][8*k +: 8] <= writedata[8*k +: 8];
                end
            end
        end
    end

    // Combinational read port: the addressed word while read is high, zero
    // otherwise. When read and write are both high, this shows the contents
    // before the write.
    // NOTE: readdata gets a default before any branch, so every path drives it
    // and no latch is inferred.
    always_comb begin
        readdata = '0;
        if (read && in_range) begin
            readdata = mem[word_idx];
        end
    end

`ifdef BUS_DATA_RAM_STALL_EN
    // ------------------------------------------------------------------
    // Wait-state FSM
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    localparam bit         STALL_ON = (WAIT_CYCLES > 0);
    // The first stall cycle is spent in IDLE, so WAIT starts one count lower.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // Next-state and waitrequest decode. Dropping the request sends the FSM
    // back to IDLE, so an abandoned access never completes later.
    always_comb begin
        state_nxt   = ST_IDLE;
        cnt_nxt     = 4'd0;
        waitrequest = 1'b0;
        if (request && STALL_ON) begin
            case (state)
                ST_IDLE: begin
                    waitrequest = 1'b1;
                    state_nxt   = ST_WAIT;
                    cnt_nxt     = CNT_LOAD;
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        waitrequest = 1'b1;
                        state_nxt   = ST_WAIT;
                        cnt_nxt     = cnt - 4'd1;
                    end
                    // When cnt reaches zero, the access completes in this cycle
                    // and the defaults return the FSM to IDLE.
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        if (reset) begin
            waitrequest = 1'b0;
        end
    end

    // State and counter registers. Reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
`else
    // Wait states are not built: every request completes in its first cycle.
    assign waitrequest = 1'b0;

    // WAIT_CYCLES has no meaning in this build.
    logic [3:0] unused_wait_cfg;
    assign unused_wait_cfg = 4'(WAIT_CYCLES);
`endif

endmodule

// File: tb/tb_bus_data_ram.sv
// Self-checking bench for bus_data_ram.
// The driver issues one bus access at a time and pushes the expected result.
// The expectation comes from a flat array model or a fixed constant.
// A separate monitor watches the bus on falling edges. For each completion it
// pops the expectation and compares the stall length and the read data.
// The bench follows whichever BUS_DATA_RAM_STALL_EN setting the RTL was built with.

module tb_bus_data_ram;

    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          DEPTH    = 256;
    localparam int          WAITC    = 2;
    localparam logic [31:0] END_ADDR = BASE + 32'(4 * DEPTH);
`ifdef BUS_DATA_RAM_STALL_EN
    localparam int          EXP_STALL = WAITC;
`else
    localparam int          EXP_STALL = 0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          stall;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];

    bus_data_ram #(
        .BASE_ADDR     (BASE),
        .DEPTH_WORDS   (DEPTH),
        .WAIT_CYCLES   (WAITC),
        .RAM_INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_hit(input logic [31:0] a);
        longint off;
        off = longint'({32'd0, a}) - longint'({32'd0, BASE});
        return (off >= 0) && (off < longint'(4 * DEPTH));
    endfunction

    // Returns what a read sees, which is the contents before any write, and
    // then applies the write.
    function automatic logic [31:0] model_access(input bit rd, input bit wr, input logic [31:0] a,
                                                 input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] rv;
        int          idx;
        rv = '0;
        if (model_hit(a)) begin
            idx = int'((longint'({32'd0, a}) - longint'({32'd0, BASE})) / 4);
            if (rd) rv = ref_mem[idx];
            if (wr) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
                end
            end
        end
        return rv;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        int   stall_run;
        exp_t e;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (reset || !(read || write)) begin
                stall_run = 0;
            end else if (waitrequest) begin
                stall_run++;
            end else begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_completion: got a completion at cycle %0d, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_stall"}, stall_run, e.stall);
                    if (e.is_read) check({e.tag, "_rdata"}, readdata, e.data);
                end
                stall_run = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Waits for the completing cycle, then steps to just after the edge that closes it.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!waitrequest) break;
            n++;
            if (n > 40) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_timeout: waitrequest still 1 after %0d cycles, want 0", tag, n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input string tag);
        exp_t e;
        address = a; read = rd; write = wr; byteenable = be; writedata = wd;
        e.is_read = rd;
        e.stall   = EXP_STALL;
        e.tag     = tag;
        e.data    = model_access(rd, wr, a, be, wd);
        sb.push_back(e);
        wait_done(tag);
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        address = a; read = 1'b1; write = 1'b0; byteenable = 4'h0; writedata = '0;
        e.is_read = 1'b1;
        e.stall   = EXP_STALL;
        e.tag     = tag;
        e.data    = exp;
        sb.push_back(e);
        wait_done(tag);
    endtask

    // Drives junk address and data during the stall cycles and the real values
    // only in the completing cycle.
    task automatic write_late(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                              input string tag);
        exp_t e;
        address = BASE + 32'h20; byteenable = 4'hF; writedata = 32'hFFFF_FFFF;
        read = 1'b0; write = 1'b1;
        e.is_read = 1'b0;
        e.stall   = EXP_STALL;
        e.tag     = tag;
        e.data    = '0;
        void'(model_access(1'b0, 1'b1, a, be, wd));
        sb.push_back(e);
        repeat (EXP_STALL) begin
            @(posedge clk);
            #1;
        end
        address = a; byteenable = be; writedata = wd;
        wait_done(tag);
    endtask

    task automatic idle_cycles(input int n);
        read = 1'b0;
        write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int c1;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = BASE; byteenable = 4'h0; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        check("rst_rdata_idle", readdata, 32'd0);

        // A write held during reset must not commit.
        address = BASE + 32'h10; write = 1'b1; byteenable = 4'hF; writedata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_write_waitreq", {31'd0, waitrequest}, 32'd0);
        write = 1'b0;
        reset = 1'b0;
        idle_cycles(1);
        read_expect(BASE + 32'h10, 32'h0, "rst_no_commit");
        idle_cycles(1);

        // Full-word write and read back.
        access(1'b0, 1'b1, BASE + 32'h100, 4'hF, 32'h1234_5678, "full_wr");
        read_expect(BASE + 32'h100, 32'h1234_5678, "full_rd");

        // Byte-lane merge.
        access(1'b0, 1'b1, BASE + 32'h100, 4'b0101, 32'hAABB_CCDD, "lane_wr");
        read_expect(BASE + 32'h100, 32'h12BB_56DD, "lane_rd");

        // readdata is zero whenever read is low.
        idle_cycles(0);
        address = BASE + 32'h100;
        #1;
        check("rdata_no_read", readdata, 32'd0);
        idle_cycles(1);

        // Out-of-window accesses.
        read_expect(END_ADDR, 32'h0, "oob_top_rd");
        access(1'b0, 1'b1, END_ADDR, 4'hF, 32'hFFFF_FFFF, "oob_top_wr");
        read_expect(BASE - 32'd4, 32'h0, "oob_low_rd");
        access(1'b0, 1'b1, BASE - 32'd4, 4'hF, 32'hFFFF_FFFF, "oob_low_wr");
        read_expect(BASE, 32'h0, "oob_word0");
        read_expect(BASE + 32'(4 * (DEPTH - 1)), 32'h0, "oob_wordlast");
        read_expect(BASE + 32'h100, 32'h12BB_56DD, "oob_word100");
        idle_cycles(1);

`ifdef BUS_DATA_RAM_STALL_EN
        // Abandon a read after one wait cycle, then issue a fresh write.
        address = BASE + 32'h100; read = 1'b1; write = 1'b0;
        @(negedge clk);
        check("abandon_wait1", {31'd0, waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        idle_cycles(1);
        access(1'b0, 1'b1, BASE + 32'h104, 4'hF, 32'h0BAD_F00D, "after_abandon_wr");
        read_expect(BASE + 32'h104, 32'h0BAD_F00D, "after_abandon_rd");
        idle_cycles(1);
`endif

        // Only values present in the completing cycle may be used.
        write_late(BASE + 32'h24, 4'hF, 32'hCAFE_0124, "late_wr");
        read_expect(BASE + 32'h20, 32'h0, "late_junk_untouched");
        read_expect(BASE + 32'h24, 32'hCAFE_0124, "late_rd");
        idle_cycles(1);

        // Reset in the middle of a stalled write.
        access(1'b0, 1'b1, BASE + 32'h40, 4'hF, 32'h1122_3344, "pre_rst_wr");
        idle_cycles(1);
`ifdef BUS_DATA_RAM_STALL_EN
        address = BASE + 32'h40; write = 1'b1; read = 1'b0;
        byteenable = 4'hF; writedata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_in_wait", {31'd0, waitrequest}, 32'd1);
        #1 reset = 1'b1;
        #1 check("rst_mid_waitreq", {31'd0, waitrequest}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        write = 1'b0;
        reset = 1'b0;
        idle_cycles(1);
`endif
        read_expect(BASE + 32'h40, 32'h1122_3344, "rst_mid_keep");
        idle_cycles(1);

        // Back-to-back reads of four consecutive words.
        for (int k = 0; k < 4; k++) begin
            access(1'b0, 1'b1, BASE + 32'h200 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k),
                   $sformatf("b2b_wr%0d", k));
        end
        idle_cycles(1);
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            read_expect(BASE + 32'h200 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), $sformatf("b2b_rd%0d", k));
        end
        c1 = cyc;
        check("b2b_cycles", 32'(c1 - c0), 32'(4 * (EXP_STALL + 1)));
        idle_cycles(1);

        // Randomized traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            int          sel;
            int          op;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            op  = int'($urandom_range(0, 2));
            if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            else if (sel == 7) a = BASE + 32'(4 * (DEPTH - 1));
            else if (sel == 8) a = END_ADDR + 32'(4 * $urandom_range(0, 3));
            else               a = BASE - 32'd4;
            access(op != 1, op != 0, a, 4'($urandom_range(0, 15)), $urandom, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end

        idle_cycles(2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_data_ram.md
BUS_DATA_RAM -- requirements
Module: bus_data_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted per access (0..15).
REQ-004 SHALL have parameter RAM_INIT_FILE, default "": hex image loaded at time zero; empty string means all words zero.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port address, input, 32 bits: byte address from the CPU; bits [1:0] ignored.
REQ-008 SHALL have port read, input, 1 bit: read request.
REQ-009 SHALL have port write, input, 1 bit: write request.
REQ-010 SHALL have port byteenable, input, 4 bits: lane k enables writedata[8k+7:8k].
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port waitrequest, output, 1 bit: high means the current request is not yet accepted.
REQ-013 SHALL have port readdata, output, 32 bits: read data, valid in the cycle read=1 and waitrequest=0.

Function
REQ-014 SHALL treat request = read | write; write has priority when both are high, and readdata then shows pre-write contents.
REQ-015 SHALL store bytes so that byte address A+k maps to lane k of the word at A (A word-aligned).
REQ-016 SHALL implement FSM states IDLE and WAIT with a 4-bit down-counter cnt.
REQ-017 In IDLE with request=1 and WAIT_CYCLES>0: waitrequest=1 combinationally; next state WAIT with cnt=WAIT_CYCLES-1.
REQ-018 In WAIT with request=1 and cnt!=0: waitrequest=1; cnt decrements.
REQ-019 In WAIT with request=1 and cnt==0: waitrequest=0; the access completes this cycle; next state IDLE.
REQ-020 Each access therefore shows exactly WAIT_CYCLES cycles of waitrequest=1, then completes in cycle WAIT_CYCLES+1; back-to-back requests each re-incur the full stall.
REQ-021 With WAIT_CYCLES=0: waitrequest=0 always; every request completes in its first cycle.
REQ-022 In any state with request=0: waitrequest=0; next state IDLE, so an abandoned request is discarded.
REQ-023 Address, byteenable and writedata SHALL be sampled only in the completing cycle.
REQ-024 A write commits the enabled lanes at the rising edge ending the completing cycle; disabled lanes are unchanged.
REQ-025 readdata SHALL be driven combinationally from the addressed word when read=1, and SHALL be 0 otherwise.
REQ-026 An address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL read 0 and drop writes, with normal wait-state timing.

Reset
REQ-027 While reset=1: state=IDLE, cnt=0, waitrequest=0, and no write commits; readdata follows REQ-025.
REQ-028 Reset asserted mid-access SHALL abort the access immediately; memory contents are never cleared by reset.

Configuration
REQ-029 Macro BUS_DATA_RAM_STALL_EN SHALL control wait-state support.
REQ-030 With BUS_DATA_RAM_STALL_EN defined, behaviour follows REQ-017 to REQ-022.
REQ-031 Without BUS_DATA_RAM_STALL_EN, the FSM and counter SHALL be omitted, waitrequest SHALL be tied 0, and WAIT_CYCLES SHALL be ignored.

Verification
REQ-032 With the macro on and WAIT_CYCLES=2, the bench writes 32'h12345678 with byteenable=4'hF at BASE_ADDR+32'h100 -> waitrequest is 1,1,0 and a read back returns 32'h12345678.
REQ-033 Over word 32'h12345678, the bench writes 32'hAABBCCDD with byteenable=4'b0101 -> a read returns 32'h12BB56DD.
REQ-034 The bench asserts read at BASE_ADDR+4*DEPTH_WORDS -> waitrequest is high for 2 cycles, then readdata=0; a write to that address leaves all words unchanged.
REQ-035 The bench drops read after 1 wait cycle and then issues a new write -> the write sees the full 2-cycle stall and no stale completion occurs.
REQ-036 The bench asserts reset during the WAIT state of a write of 32'hDEADBEEF -> waitrequest=0 immediately and the target word keeps its prior value.
REQ-037 With the macro off, the bench issues back-to-back reads of 4 consecutive words -> waitrequest stays 0 and one word is returned per cycle.
